// File: rtl/ascon_sbox_iter.sv
// rtl/ascon_sbox_iter.sv - iterative bitsliced Ascon S-box layer over a 5-lane state
module ascon_sbox_iter #(
   parameter int LANE_W  = 64,
   parameter int SLICE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LANE_W-1:0] x0_in,
   input  logic [LANE_W-1:0] x1_in,
   input  logic [LANE_W-1:0] x2_in,
   input  logic [LANE_W-1:0] x3_in,
   input  logic [LANE_W-1:0] x4_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] x0_out,
   output logic [LANE_W-1:0] x1_out,
   output logic [LANE_W-1:0] x2_out,
   output logic [LANE_W-1:0] x3_out,
   output logic [LANE_W-1:0] x4_out,
   output logic              busy
);

   localparam int NSTEP = LANE_W / SLICE_W;
   localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt;
   logic [LANE_W-1:0]  s0, s1, s2, s3, s4;
   logic [LANE_W-1:0]  n0, n1, n2, n3, n4;
   logic [SLICE_W-1:0] sl0, sl1, sl2, sl3, sl4;
   logic [SLICE_W-1:0] t0, t1, t2, t3, t4;
   logic [SLICE_W-1:0] c0, c1, c2, c3, c4;
   logic [SLICE_W-1:0] sb0, sb1, sb2, sb3, sb4;
   logic               accept;
   logic               last_step;

   assign accept    = in_valid & in_ready;
   assign last_step = (cnt == CNT_W'(NSTEP - 1));

   // Pick the column slice addressed by the step counter (constant slices, one per step).
   always_comb begin
      sl0 = '0;
      sl1 = '0;
      sl2 = '0;
      sl3 = '0;
      sl4 = '0;
      for (int k = 0; k < NSTEP; k++) begin
         if (cnt == CNT_W'(k)) begin
            sl0 = s0[k*SLICE_W +: SLICE_W];
            sl1 = s1[k*SLICE_W +: SLICE_W];
            sl2 = s2[k*SLICE_W +: SLICE_W];
            sl3 = s3[k*SLICE_W +: SLICE_W];
            sl4 = s4[k*SLICE_W +: SLICE_W];
         end
      end
   end

   // Bitsliced chi form of the Ascon S-box: xor-in, and-not, xor-out, invert lane 2.
   always_comb begin
      t0  = sl0 ^ sl4;
      t1  = sl1;
      t2  = sl2 ^ sl1;
      t3  = sl3;
      t4  = sl4 ^ sl3;
      c0  = t0 ^ (~t1 & t2);
      c1  = t1 ^ (~t2 & t3);
      c2  = t2 ^ (~t3 & t4);
      c3  = t3 ^ (~t4 & t0);
      c4  = t4 ^ (~t0 & t1);
      sb0 = c0 ^ c4;
      sb1 = c1 ^ c0;
      sb2 = ~c2;
      sb3 = c3 ^ c2;
      sb4 = c4;
   end

   // Merge the substituted slice back; all other columns keep their value.
   always_comb begin
      n0 = s0;
      n1 = s1;
      n2 = s2;
      n3 = s3;
      n4 = s4;
      for (int k = 0; k < NSTEP; k++) begin
         if (cnt == CNT_W'(k)) begin
            n0[k*SLICE_W +: SLICE_W] = sb0;
            n1[k*SLICE_W +: SLICE_W] = sb1;
            n2[k*SLICE_W +: SLICE_W] = sb2;
            n3[k*SLICE_W +: SLICE_W] = sb3;
            n4[k*SLICE_W +: SLICE_W] = sb4;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; in_ready depends only on state and out_ready.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_d = in_valid ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Lane registers and step counter: load on accept, substitute one slice per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         s0  <= '0;
         s1  <= '0;
         s2  <= '0;
         s3  <= '0;
         s4  <= '0;
      end else if (accept) begin
         cnt <= '0;
         s0  <= x0_in;
         s1  <= x1_in;
         s2  <= x2_in;
         s3  <= x3_in;
         s4  <= x4_in;
      end else if (state_q == RUN) begin
         cnt <= last_step ? '0 : cnt + 1'b1;
         s0  <= n0;
         s1  <= n1;
         s2  <= n2;
         s3  <= n3;
         s4  <= n4;
      end
   end

   assign x0_out = s0;
   assign x1_out = s1;
   assign x2_out = s2;
   assign x3_out = s3;
   assign x4_out = s4;

endmodule
